// File: rtl/venus_ex_pkg.sv
// venus_ex_pkg: shared types for the multi-cycle execute stage.
// Op/cc encodings, NZCV bit positions, divider states, cc evaluation.
package venus_ex_pkg;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_MUL,
    OP_DIVU,
    OP_REMU,
    OP_JUMP,
    OP_HALT
  } op_e;

  typedef enum logic [2:0] {
    CC_AL,
    CC_EQ,
    CC_NE,
    CC_LT,
    CC_GE,
    CC_CS,
    CC_CC,
    CC_NV
  } cc_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    DIV_IDLE,
    DIV_BUSY
  } div_state_e;

  function automatic logic cc_holds(
    input cc_e        cc,
    input logic [3:0] f
  );
    logic t;
    t = 1'b0;
    unique case (cc)
      CC_AL:   t = 1'b1;
      CC_EQ:   t = f[FLAG_Z];
      CC_NE:   t = ~f[FLAG_Z];
      CC_LT:   t = f[FLAG_N] ^ f[FLAG_V];
      CC_GE:   t = ~(f[FLAG_N] ^ f[FLAG_V]);
      CC_CS:   t = f[FLAG_C];
      CC_CC:   t = ~f[FLAG_C];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/execute_mc_if.sv
// execute_mc_if: decode -> execute valid/ready operation bundle.
// master = decode (drives op fields), slave = execute (drives ready_o).
interface execute_mc_if #(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int W_RD = 4,
  parameter int W_OP = 4,
  parameter int W_CC = 3
);

  logic            valid_i;
  logic            ready_o;
  logic [W_OP-1:0] op_i;
  logic [WORD-1:0] src_i;
  logic [WORD-1:0] dest_i;
  logic            wb_i;
  logic [W_RD-1:0] wb_rd_name_i;
  logic [ADDR-1:0] origaddr_i;
  logic [W_CC-1:0] cc_i;

  modport master (
    output valid_i,
    output op_i,
    output src_i,
    output dest_i,
    output wb_i,
    output wb_rd_name_i,
    output origaddr_i,
    output cc_i,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  op_i,
    input  src_i,
    input  dest_i,
    input  wb_i,
    input  wb_rd_name_i,
    input  origaddr_i,
    input  cc_i,
    output ready_o
  );

endinterface

// File: rtl/ex_div_iter.sv
// ex_div_iter: restoring radix-2 unsigned divider, one quotient bit/cycle.
// start_i loads operands; done_o pulses in the last BUSY cycle with
// quot_o/rem_o/dz_o valid combinationally in that same cycle.
module ex_div_iter
  import venus_ex_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [WORD-1:0] dividend_i,
  input  logic [WORD-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [WORD-1:0] quot_o,
  output logic [WORD-1:0] rem_o,
  output logic            dz_o
);

  localparam int CW = $clog2(WORD);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WORD-1:0] quo_q, quo_d;
  logic [WORD-1:0] rem_q, rem_d;
  logic [WORD-1:0] dsr_q, dsr_d;
  logic            dz_q, dz_d;

  logic [WORD:0]   rem_sh;
  logic [WORD:0]   diff;
  logic            qbit;
  logic [WORD-1:0] rem_nx;
  logic [WORD-1:0] quo_nx;

  // quo_q doubles as the dividend shift register: its MSB feeds
  // the partial remainder while quotient bits enter at the LSB.
  assign rem_sh = {rem_q, quo_q[WORD-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign qbit   = ~diff[WORD];
  assign rem_nx = qbit ? diff[WORD-1:0] : rem_sh[WORD-1:0];
  assign quo_nx = {quo_q[WORD-2:0], qbit};

  assign busy_o = (state_q == DIV_BUSY);
  assign quot_o = quo_nx;
  assign rem_o  = rem_nx;
  assign dz_o   = dz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    dz_d    = dz_q;
    done_o  = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          quo_d   = dividend_i;
          rem_d   = '0;
          dsr_d   = divisor_i;
          dz_d    = (divisor_i == '0);
        end
      end
      DIV_BUSY: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WORD - 1)) begin
          done_o  = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage (ALU/shift/mul/jump 1 cycle,
// DIVU/REMU iterative). dec: op bundle; wb_*: write-back; status_o: NZCV.
module execute_mc
  import venus_ex_pkg::*;
#(
  parameter int WORD = 32,
  parameter int ADDR = 16,
  parameter int W_RD = 4,
  parameter int W_OP = 4,
  parameter int W_CC = 3
) (
  input  logic            clk,
  input  logic            rst,
  execute_mc_if.slave     dec,
  output logic            branch_o,
  output logic [ADDR-1:0] baddr_o,
  output logic            wb_o,
  output logic [W_RD-1:0] wb_rd_name_o,
  output logic [WORD-1:0] wb_rd_data_o,
  output logic [3:0]      status_o,
  output logic            halted_o
);

  localparam int SH = $clog2(WORD);
  localparam int M  = WORD - 1;

  op_e op;
  cc_e cc;
  assign op = op_e'(dec.op_i[3:0]);
  assign cc = cc_e'(dec.cc_i[2:0]);

  logic            wb_q, wb_d;
  logic [W_RD-1:0] rd_q, rd_d;
  logic [WORD-1:0] data_q, data_d;
  logic [3:0]      status_q, status_d;
  logic            halted_q, halted_d;
  logic            prem_q, prem_d;
  logic            pwb_q, pwb_d;
  logic [W_RD-1:0] prd_q, prd_d;

  logic            accept;
  logic            is_div;
  logic            div_busy;
  logic            div_done;
  logic [WORD-1:0] div_quot;
  logic [WORD-1:0] div_rem;
  logic            div_dz;

  assign dec.ready_o = ~div_busy & ~halted_q & ~rst;
  assign accept = dec.valid_i & dec.ready_o;
  assign is_div = (op == OP_DIVU) | (op == OP_REMU);

  ex_div_iter #(
    .WORD(WORD)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept & is_div),
    .dividend_i(dec.dest_i),
    .divisor_i (dec.src_i),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot),
    .rem_o     (div_rem),
    .dz_o      (div_dz)
  );

  logic [WORD:0]   add_w;
  logic [WORD:0]   sub_w;
  logic            add_v;
  logic            sub_v;
  logic [SH-1:0]   shamt;
  logic [WORD:0]   sll_w;
  logic [WORD:0]   srl_w;
  logic [WORD:0]   sra_w;
  logic [WORD-1:0] mul_r;
  logic [WORD-1:0] link;

  // Shifts run one bit wider so the last bit shifted out lands in the
  // extra position; with amount 0 that bit is the padding zero.
  always_comb begin
    add_w = {1'b0, dec.dest_i} + {1'b0, dec.src_i};
    sub_w = {1'b0, dec.dest_i} + {1'b0, ~dec.src_i}
          + (WORD+1)'(1);
    add_v = (dec.dest_i[M] == dec.src_i[M])
          & (add_w[M] != dec.dest_i[M]);
    sub_v = (dec.dest_i[M] != dec.src_i[M])
          & (sub_w[M] != dec.dest_i[M]);
    shamt = dec.src_i[SH-1:0];
    sll_w = {1'b0, dec.dest_i} << shamt;
    srl_w = {dec.dest_i, 1'b0} >> shamt;
    sra_w = $unsigned($signed({dec.dest_i, 1'b0}) >>> shamt);
    mul_r = dec.dest_i * dec.src_i;
    link  = '0;
    link[ADDR-1:0] = dec.origaddr_i;
    link  = link + WORD'(1);
  end

  logic [WORD-1:0] res;
  logic            res_wr;
  logic            fl_upd;
  logic            c_new;
  logic            v_new;
  logic [WORD-1:0] dres;

  always_comb begin
    res    = '0;
    res_wr = 1'b0;
    fl_upd = 1'b0;
    c_new  = 1'b0;
    v_new  = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = add_w[M:0]; c_new = add_w[WORD];
        v_new = add_v; fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_SUB: begin
        res = sub_w[M:0]; c_new = sub_w[WORD];
        v_new = sub_v; fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_AND: begin
        res = dec.dest_i & dec.src_i;
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_OR: begin
        res = dec.dest_i | dec.src_i;
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_XOR: begin
        res = dec.dest_i ^ dec.src_i;
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_MUL: begin
        res = mul_r; fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_SLL: begin
        res = sll_w[M:0]; c_new = sll_w[WORD];
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_SRL: begin
        res = srl_w[WORD:1]; c_new = srl_w[0];
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_SRA: begin
        res = sra_w[WORD:1]; c_new = sra_w[0];
        fl_upd = 1'b1; res_wr = 1'b1;
      end
      OP_JUMP: begin
        res = link; res_wr = 1'b1;
      end
      default: begin
        res = '0;
      end
    endcase
  end

  always_comb begin
    wb_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    status_d = status_q;
    halted_d = halted_q;
    prem_d   = prem_q;
    pwb_d    = pwb_q;
    prd_d    = prd_q;
    branch_o = 1'b0;
    dres     = prem_q ? div_rem : div_quot;
    if (accept) begin
      if (is_div) begin
        prem_d = (op == OP_REMU);
        pwb_d  = dec.wb_i;
        prd_d  = dec.wb_rd_name_i;
      end else begin
        if (fl_upd) begin
          status_d = {res[M], res == '0, c_new, v_new};
        end
        if (res_wr & dec.wb_i) begin
          wb_d   = 1'b1;
          rd_d   = dec.wb_rd_name_i;
          data_d = res;
        end
        if (op == OP_HALT) begin
          halted_d = 1'b1;
        end
        if (op == OP_JUMP) begin
          branch_o = cc_holds(cc, status_q);
        end
      end
    end
    if (div_done) begin
      status_d = {dres[M], dres == '0, 1'b0, div_dz};
      if (pwb_q) begin
        wb_d   = 1'b1;
        rd_d   = prd_q;
        data_d = dres;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      status_q <= '0;
      halted_q <= 1'b0;
      prem_q   <= 1'b0;
      pwb_q    <= 1'b0;
      prd_q    <= '0;
    end else begin
      wb_q     <= wb_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      status_q <= status_d;
      halted_q <= halted_d;
      prem_q   <= prem_d;
      pwb_q    <= pwb_d;
      prd_q    <= prd_d;
    end
  end

  assign baddr_o      = rst ? '0 : dec.src_i[ADDR-1:0];
  assign wb_o         = wb_q;
  assign wb_rd_name_o = rd_q;
  assign wb_rd_data_o = data_q;
  assign status_o     = status_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed + random checks of execute_mc against
// an arithmetic reference model of the operation rules.
module tb_execute_mc;
  import venus_ex_pkg::*;

  logic        clk;
  logic        rst;
  logic        branch_o;
  logic [15:0] baddr_o;
  logic        wb_o;
  logic [3:0]  wb_rd_name_o;
  logic [31:0] wb_rd_data_o;
  logic [3:0]  status_o;
  logic        halted_o;

  execute_mc_if #(
    .WORD(32), .ADDR(16), .W_RD(4), .W_OP(4), .W_CC(3)
  ) dec_if ();

  execute_mc #(
    .WORD(32), .ADDR(16), .W_RD(4), .W_OP(4), .W_CC(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dec         (dec_if),
    .branch_o    (branch_o),
    .baddr_o     (baddr_o),
    .wb_o        (wb_o),
    .wb_rd_name_o(wb_rd_name_o),
    .wb_rd_data_o(wb_rd_data_o),
    .status_o    (status_o),
    .halted_o    (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_st;
  logic        m_halt;
  logic [31:0] m_data;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] fl(input logic [31:0] r,
                                    input logic c,
                                    input logic v);
    return {r[31], r == 32'd0, c, v};
  endfunction

  function automatic logic ovf(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  task automatic model(input op_e op,
                       input logic [31:0] s,
                       input logic [31:0] d,
                       input logic [15:0] org,
                       input logic [2:0] cc,
                       output logic [31:0] r,
                       output logic wr,
                       output logic br,
                       output logic [3:0] st_n);
    logic [32:0] u;
    longint sd;
    int k;
    logic c;
    r = '0; wr = 1'b0; br = 1'b0; st_n = m_st;
    k = int'(s[4:0]); c = 1'b0;
    case (op)
      OP_ADD: begin
        u = {1'b0, d} + {1'b0, s}; r = u[31:0];
        sd = longint'($signed(d)) + longint'($signed(s));
        st_n = fl(r, u[32], ovf(sd)); wr = 1'b1;
      end
      OP_SUB: begin
        r = d - s;
        sd = longint'($signed(d)) - longint'($signed(s));
        st_n = fl(r, d >= s, ovf(sd)); wr = 1'b1;
      end
      OP_AND: begin r = d & s; st_n = fl(r, 0, 0); wr = 1'b1; end
      OP_OR:  begin r = d | s; st_n = fl(r, 0, 0); wr = 1'b1; end
      OP_XOR: begin r = d ^ s; st_n = fl(r, 0, 0); wr = 1'b1; end
      OP_MUL: begin r = d * s; st_n = fl(r, 0, 0); wr = 1'b1; end
      OP_SLL: begin
        r = d << k; if (k != 0) c = d[32-k];
        st_n = fl(r, c, 0); wr = 1'b1;
      end
      OP_SRL: begin
        r = d >> k; if (k != 0) c = d[k-1];
        st_n = fl(r, c, 0); wr = 1'b1;
      end
      OP_SRA: begin
        r = $signed(d) >>> k; if (k != 0) c = d[k-1];
        st_n = fl(r, c, 0); wr = 1'b1;
      end
      OP_DIVU: begin
        r = (s == 0) ? 32'hFFFF_FFFF : d / s;
        st_n = fl(r, 0, s == 0); wr = 1'b1;
      end
      OP_REMU: begin
        r = (s == 0) ? d : d % s;
        st_n = fl(r, 0, s == 0); wr = 1'b1;
      end
      OP_JUMP: begin
        r = 32'(org) + 32'd1; wr = 1'b1;
        case (cc)
          3'd0: br = 1'b1;
          3'd1: br = m_st[2];
          3'd2: br = !m_st[2];
          3'd3: br = m_st[3] != m_st[0];
          3'd4: br = m_st[3] == m_st[0];
          3'd5: br = m_st[1];
          3'd6: br = !m_st[1];
          default: br = 1'b0;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic issue(input op_e op,
                       input logic [31:0] s,
                       input logic [31:0] d,
                       input logic w,
                       input logic [3:0] rd,
                       input logic [15:0] org,
                       input logic [2:0] cc);
    logic [31:0] r;
    logic wr, br, acc, isdiv, ewb;
    logic [3:0] st_n;
    model(op, s, d, org, cc, r, wr, br, st_n);
    acc = !m_halt;
    isdiv = (op == OP_DIVU) || (op == OP_REMU);
    ewb = acc & w & wr;
    @(negedge clk);
    dec_if.op_i = op;
    dec_if.src_i = s;
    dec_if.dest_i = d;
    dec_if.wb_i = w;
    dec_if.wb_rd_name_i = rd;
    dec_if.origaddr_i = org;
    dec_if.cc_i = cc;
    dec_if.valid_i = 1'b1;
    #2;
    check("ready", 64'(dec_if.ready_o), 64'(acc));
    check("branch", 64'(branch_o), 64'(acc & br));
    if (acc && op == OP_JUMP)
      check("baddr", 64'(baddr_o), 64'(s[15:0]));
    @(posedge clk); #1;
    if (acc) begin
      m_st = st_n;
      if (op == OP_HALT) m_halt = 1'b1;
      if (ewb) m_data = r;
    end
    if (isdiv && acc) begin
      // valid_i stays high through BUSY; it must be ignored
      for (int i = 1; i <= 32; i++) begin
        check("busy", 64'({dec_if.ready_o, wb_o}), 64'(2'b00));
        @(posedge clk); #1;
      end
    end
    dec_if.valid_i = 1'b0;
    check("wb", 64'(wb_o), 64'(ewb));
    if (ewb) check("name", 64'(wb_rd_name_o), 64'(rd));
    check("data", 64'(wb_rd_data_o), 64'(m_data));
    check("status", 64'(status_o), 64'(m_st));
    check("halted", 64'(halted_o), 64'(m_halt));
    if (isdiv && acc) begin
      check("rdy_done", 64'(dec_if.ready_o), 64'(1'b1));
      @(posedge clk); #1;
      check("nodup", 64'(wb_o), 64'(1'b0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dec_if.valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_st = '0; m_halt = 1'b0; m_data = '0;
    check("rst_wb", 64'(wb_o), 64'(1'b0));
    check("rst_data", 64'(wb_rd_data_o), 64'(32'd0));
    check("rst_name", 64'(wb_rd_name_o), 64'(4'd0));
    check("rst_stat", 64'(status_o), 64'(4'd0));
    check("rst_halt", 64'(halted_o), 64'(1'b0));
    check("rst_rdy", 64'(dec_if.ready_o), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdy_post", 64'(dec_if.ready_o), 64'(1'b1));
  endtask

  op_e pool [11] = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
                     OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL,
                     OP_JUMP};

  initial begin
    logic seen_wb;
    op_e  op;
    logic [31:0] s;
    rst = 1'b1;
    dec_if.valid_i = 1'b0;
    dec_if.op_i = '0;
    dec_if.src_i = '0;
    dec_if.dest_i = '0;
    dec_if.wb_i = 1'b0;
    dec_if.wb_rd_name_i = '0;
    dec_if.origaddr_i = '0;
    dec_if.cc_i = '0;
    m_st = '0; m_halt = 1'b0; m_data = '0;
    do_reset();

    issue(OP_ADD, 32'd1, 32'h7FFF_FFFF, 1, 4'd3, 16'd0, 3'd0);
    check("add_k", 64'(wb_rd_data_o), 64'(32'h8000_0000));
    check("add_f", 64'(status_o), 64'(4'b1001));

    issue(OP_SUB, 32'd5, 32'd5, 1, 4'd1, 16'd0, 3'd0);
    issue(OP_JUMP, 32'h40, 32'd0, 1, 4'd15, 16'h10, 3'd1);
    check("link_k", 64'(wb_rd_data_o), 64'(32'h11));
    issue(OP_SUB, 32'd5, 32'd5, 1, 4'd1, 16'd0, 3'd0);
    issue(OP_JUMP, 32'h40, 32'd0, 1, 4'd15, 16'h10, 3'd2);
    check("link_nt", 64'(wb_rd_data_o), 64'(32'h11));

    issue(OP_DIVU, 32'd7, 32'd100, 1, 4'd4, 16'd0, 3'd0);
    check("divu_k", 64'(wb_rd_data_o), 64'(32'd14));
    issue(OP_REMU, 32'd7, 32'd100, 1, 4'd4, 16'd0, 3'd0);
    check("remu_k", 64'(wb_rd_data_o), 64'(32'd2));
    issue(OP_DIVU, 32'd0, 32'd9, 1, 4'd5, 16'd0, 3'd0);
    check("dz_q", 64'(wb_rd_data_o), 64'(32'hFFFF_FFFF));
    check("dz_v", 64'(status_o[0]), 64'(1'b1));
    issue(OP_REMU, 32'd0, 32'd9, 1, 4'd5, 16'd0, 3'd0);
    check("dz_r", 64'(wb_rd_data_o), 64'(32'd9));
    check("dz_rv", 64'(status_o[0]), 64'(1'b1));

    issue(OP_SRA, 32'd1, 32'h8000_0001, 1, 4'd6, 16'd0, 3'd0);
    check("sra_k", 64'(wb_rd_data_o), 64'(32'hC000_0000));
    check("sra_f", 64'(status_o), 64'(4'b1010));
    issue(OP_SLL, 32'd0, 32'hFFFF_FFFF, 1, 4'd6, 16'd0, 3'd0);
    check("sll0_c", 64'(status_o[1]), 64'(1'b0));
    issue(OP_NOP, 32'd3, 32'd3, 1, 4'd2, 16'd0, 3'd0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        op = ($urandom_range(0, 1) == 0) ? OP_DIVU : OP_REMU;
      else
        op = pool[$urandom_range(0, 10)];
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'($urandom_range(0, 3));
      issue(op, s, $urandom, $urandom_range(0, 3) != 0,
            4'($urandom), 16'($urandom), 3'($urandom));
    end

    issue(OP_HALT, 32'd0, 32'd0, 1, 4'd7, 16'd0, 3'd0);
    check("halt_k", 64'(halted_o), 64'(1'b1));
    issue(OP_ADD, 32'd1, 32'd2, 1, 4'd8, 16'd0, 3'd0);
    repeat (5) @(posedge clk);
    #1;
    check("halt_rdy", 64'(dec_if.ready_o), 64'(1'b0));

    do_reset();
    @(negedge clk);
    dec_if.op_i = OP_DIVU;
    dec_if.src_i = 32'd7;
    dec_if.dest_i = 32'd100;
    dec_if.wb_i = 1'b1;
    dec_if.wb_rd_name_i = 4'd9;
    dec_if.valid_i = 1'b1;
    @(posedge clk); #1;
    dec_if.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_wb", 64'(wb_o), 64'(1'b0));
    check("mr_data", 64'(wb_rd_data_o), 64'(32'd0));
    check("mr_stat", 64'(status_o), 64'(4'd0));
    check("mr_halt", 64'(halted_o), 64'(1'b0));
    check("mr_rdy", 64'(dec_if.ready_o), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_rdy1", 64'(dec_if.ready_o), 64'(1'b1));
    seen_wb = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_o) seen_wb = 1'b1;
    end
    check("mr_nowb", 64'(seen_wb), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
Parametrised multi-cycle execute stage. It sits between decode and the register file.
- Accepts one operation per valid/ready handshake.
- Computes ALU, shift, multiply and branch results in one cycle; division and remainder run on an iterative radix-2 divider.
- Keeps a NZCV status register for conditional jumps and latches a halt state.

Parameters:
WORD, 32, datapath width (≥4)
ADDR, 16, instruction address width (≤ WORD)
W_RD, 4, destination register name width
W_OP, 4, operation code width
W_CC, 3, condition code width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  decode presents an operation
ready_o  out  1  stage can accept an operation this cycle
op_i  in  W_OP  operation (encoding from package)
src_i  in  WORD  source operand / jump target
dest_i  in  WORD  second operand (dividend, minuend, shifted value)
wb_i  in  1  operation writes a register
wb_rd_name_i  in  W_RD  destination register
origaddr_i  in  ADDR  address of this instruction
cc_i  in  W_CC  jump condition
branch_o  out  1  taken jump, combinational, valid in the accept cycle
baddr_o  out  ADDR  jump target = src_i[ADDR-1:0]
wb_o  out  1  one-cycle write-back pulse
wb_rd_name_o  out  W_RD  write-back register
wb_rd_data_o  out  WORD  write-back data; holds its last value when wb_o=0
status_o  out  4  {N,Z,C,V} register
halted_o  out  1  halt latched

Behaviour:
- Reset (rst=1 at posedge): outputs are 0, divider goes IDLE, status is 0, halted is 0. Reset mid-divide abandons the operation with no write-back. ready_o=0 during reset.
- Accept = valid_i & ready_o. ready_o = ~busy & ~halted & ~rst.
- Single-cycle ops: ADD, SUB (dest-src), AND, OR, XOR, SLL, SRL, SRA, MUL (low WORD bits), JUMP, HALT, NOP.
  - Result, wb_o and status are registered at the accept edge, so wb_o is high in cycle t+1.
- Flags:
  - ADD/SUB: N, Z, C (carry out / no-borrow), V (signed overflow).
  - Logic and MUL: N and Z updated; C and V cleared.
  - Shifts: N and Z updated; C = last bit shifted out, or 0 when the amount is 0; V cleared.
  - Shift amount = src_i[$clog2(WORD)-1:0].
  - JUMP, HALT, NOP: flags unchanged.
- JUMP condition on current status_o, cc: 0 always, 1 EQ(Z), 2 NE, 3 LT(N^V), 4 GE, 5 CS(C), 6 CC, 7 never.
  - branch_o = accept & JUMP & cond.
  - With wb_i set, the link value origaddr_i+1 (zero-extended) is written back regardless of cond.
- DIVU/REMU (unsigned, dest/src):
  - Accept at cycle t loads the operands and enters BUSY; ready_o is 0 for cycles t+1..t+WORD.
  - One quotient bit per cycle.
  - wb_o, data and flags (N, Z; C=0) are registered at the end of cycle t+WORD, so wb_o is high in cycle t+WORD+1. ready_o returns high in that same cycle.
- Divide by zero: completes with the same latency. Quotient is all ones, remainder = dest, V=1.
- wb_o = registered (wb_i & op writes a value). Ops that write no value (HALT, NOP) never assert wb_o.
- HALT accept sets halted (sticky until rst); ready_o drops from t+1.
- valid_i while ready_o=0: ignored, no state change.
- Status is updated in order. A JUMP accepted at t+1 sees flags from an op accepted at t.

Decomposition:
- Package venus_ex_pkg:
  - op enum (NOP, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, MUL, DIVU, REMU, JUMP, HALT)
  - cc enum
  - flag bit indices N=3, Z=2, C=1, V=0
  - divider state enum (IDLE, BUSY)
- Sub-module ex_div_iter: restoring divider with start/done handshake, parametrised by WORD, returning quotient, remainder and divide-by-zero.

Test Plan:
- ADD dest=0x7FFFFFFF, src=1, rd=3 → cycle t+1: wb_o=1, name=3, data=0x80000000, status N=1 Z=0 C=0 V=1.
- SUB dest=5, src=5, then JUMP cc=1 src=0x0040 origaddr=0x0010 wb_i=1 rd=15 → branch_o=1 in the jump cycle, baddr_o=0x0040, r15 written 0x00000011. Repeat with cc=2 → branch_o=0, link still written.
- DIVU dest=100, src=7 at t → ready_o=0 for t+1..t+32; wb_o=1 only at t+33 with data 14. REMU with the same operands gives 2. valid_i held high during BUSY is not accepted.
- DIVU src=0, dest=9 → t+33 data=0xFFFFFFFF, V=1. REMU gives 9, V=1.
- SRA dest=0x80000001, src=1 → data 0xC0000000, C=1, N=1. SLL amount 0 → C=0.
- HALT → halted_o=1, ready_o=0 forever, a following ADD is never written back. rst at t+10 of a DIVU → no wb_o, all outputs 0, ready_o=1 the cycle after rst drops.
